// File: rtl/alu_status_unit.sv
// ---------------------------------------------------------------------------
// alu_status_unit
//   Receive side of the ALU flag interface for the MIPS-lite datapath.
//   - Captures the ALU zero/overflow/negative flags into a status register.
//   - Evaluates branch conditions against the captured flags. If the flags
//     are being written in the same cycle, the incoming values are used.
//   - Counts overflow events in a saturating counter.
//   - Raises an overflow trap that stays pending until it is acknowledged.
//
// Parameters
//   CNT_W     width of the saturating overflow event counter
//   TRAP_EN   1: an overflow raises ovf_trap; 0: overflows are only counted
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   zin        in   ALU zero flag
//   vin        in   ALU overflow flag
//   nin        in   ALU negative flag
//   flag_we    in   capture zin/vin/nin this cycle
//   br_req     in   branch evaluation request (one-cycle pulse)
//   cond       in   condition code, sampled together with br_req
//   trap_ack   in   acknowledge / clear the pending overflow trap
//   cnt_clr    in   synchronous clear of ovf_count
//   zflag      out  registered Z
//   vflag      out  registered V
//   nflag      out  registered N
//   br_valid   out  branch decision valid, one cycle after br_req
//   br_taken   out  branch decision, meaningful while br_valid=1
//   ovf_trap   out  overflow trap pending
//   ovf_count  out  number of captured overflows, saturating
// ---------------------------------------------------------------------------
module alu_status_unit #(
    parameter int CNT_W   = 8,
    parameter int TRAP_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             zin,
    input  logic             vin,
    input  logic             nin,
    input  logic             flag_we,
    input  logic             br_req,
    input  logic [2:0]       cond,
    input  logic             trap_ack,
    input  logic             cnt_clr,
    output logic             zflag,
    output logic             vflag,
    output logic             nflag,
    output logic             br_valid,
    output logic             br_taken,
    output logic             ovf_trap,
    output logic [CNT_W-1:0] ovf_count
);

    typedef enum logic {
        IDLE = 1'b0,
        TRAP = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic ovf_event;
    logic f_z;
    logic f_v;
    logic f_n;
    logic cond_true;

    assign ovf_event = flag_we & vin;

    // Status register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zflag <= 1'b0;
            vflag <= 1'b0;
            nflag <= 1'b0;
        end else if (flag_we) begin
            zflag <= zin;
            vflag <= vin;
            nflag <= nin;
        end
    end

    // Forward the flags being written this cycle so a branch issued alongside
    // the ALU result sees the new flags rather than the stale register.
    always_comb begin
        f_z = zflag;
        f_v = vflag;
        f_n = nflag;
        if (flag_we) begin
            f_z = zin;
            f_v = vin;
            f_n = nin;
        end
    end

    always_comb begin
        cond_true = 1'b0;
        unique case (cond)
            3'b000: cond_true = 1'b0;
            3'b001: cond_true = f_z;
            3'b010: cond_true = ~f_z;
            3'b011: cond_true = f_n;
            3'b100: cond_true = ~f_n;
            3'b101: cond_true = f_v;
            3'b110: cond_true = f_n ^ f_v;   // signed less-than
            3'b111: cond_true = 1'b1;
        endcase
    end

    // Branch decision: registered, so each request yields exactly one
    // valid cycle and back-to-back requests pipeline at one per clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_valid <= 1'b0;
            br_taken <= 1'b0;
        end else begin
            br_valid <= br_req;
            br_taken <= br_req & cond_true;
        end
    end

    // Saturating overflow counter; a clear in the same cycle as an overflow
    // wins and that event is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_count <= '0;
        end else if (cnt_clr) begin
            ovf_count <= '0;
        end else if (ovf_event && (ovf_count != '1)) begin
            ovf_count <= ovf_count + 1'b1;
        end
    end

    // Trap FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (ovf_event && (TRAP_EN != 0)) begin
                    state_next = TRAP;
                end
            end
            TRAP: begin
                // An overflow arriving with the ack re-arms the trap.
                if (trap_ack && !ovf_event) begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    assign ovf_trap = (state == TRAP);

endmodule

// File: tb/tb_alu_status_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_status_unit
//   Directed self-checking bench for alu_status_unit. Three instances share
//   the same stimulus: default parameters, a 2-bit counter variant and a
//   variant with the trap disabled.
// ---------------------------------------------------------------------------
module tb_alu_status_unit;

    logic       clk;
    logic       reset;
    logic       zin, vin, nin, flag_we, br_req, trap_ack, cnt_clr;
    logic [2:0] cond;

    logic       zflag, vflag, nflag, br_valid, br_taken, ovf_trap;
    logic [7:0] ovf_count;

    logic       s_zflag, s_vflag, s_nflag, s_br_valid, s_br_taken, s_ovf_trap;
    logic [1:0] s_ovf_count;

    logic       d_zflag, d_vflag, d_nflag, d_br_valid, d_br_taken, d_ovf_trap;
    logic [7:0] d_ovf_count;

    int n_checks = 0;
    int n_fail   = 0;

    alu_status_unit #(.CNT_W(8), .TRAP_EN(1)) u_dut (
        .clk(clk), .reset(reset), .zin(zin), .vin(vin), .nin(nin),
        .flag_we(flag_we), .br_req(br_req), .cond(cond), .trap_ack(trap_ack),
        .cnt_clr(cnt_clr), .zflag(zflag), .vflag(vflag), .nflag(nflag),
        .br_valid(br_valid), .br_taken(br_taken), .ovf_trap(ovf_trap),
        .ovf_count(ovf_count)
    );

    alu_status_unit #(.CNT_W(2), .TRAP_EN(1)) u_sat (
        .clk(clk), .reset(reset), .zin(zin), .vin(vin), .nin(nin),
        .flag_we(flag_we), .br_req(br_req), .cond(cond), .trap_ack(trap_ack),
        .cnt_clr(cnt_clr), .zflag(s_zflag), .vflag(s_vflag), .nflag(s_nflag),
        .br_valid(s_br_valid), .br_taken(s_br_taken), .ovf_trap(s_ovf_trap),
        .ovf_count(s_ovf_count)
    );

    alu_status_unit #(.CNT_W(8), .TRAP_EN(0)) u_noen (
        .clk(clk), .reset(reset), .zin(zin), .vin(vin), .nin(nin),
        .flag_we(flag_we), .br_req(br_req), .cond(cond), .trap_ack(trap_ack),
        .cnt_clr(cnt_clr), .zflag(d_zflag), .vflag(d_vflag), .nflag(d_nflag),
        .br_valid(d_br_valid), .br_taken(d_br_taken), .ovf_trap(d_ovf_trap),
        .ovf_count(d_ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clr_inputs();
        zin = 0; vin = 0; nin = 0; flag_we = 0; br_req = 0;
        cond = 3'b000; trap_ack = 0; cnt_clr = 0;
    endtask

    // Advance one rising edge and land 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({zflag, vflag, nflag, br_valid, br_taken, ovf_trap} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 000000",
                     {zflag, vflag, nflag, br_valid, br_taken, ovf_trap});
        end
        n_checks++;
        if (ovf_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d want 0", ovf_count);
        end
    endtask

    // Reset asserted mid-trap with count 5 clears everything before the next edge.
    task automatic test_reset_mid_trap();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            flag_we = 1; vin = 1;
            if (i == 4) begin br_req = 1; cond = 3'b111; end
            tick();
        end
        clr_inputs();
        n_checks++;
        if ({ovf_trap, vflag, br_valid} !== 3'b111 || ovf_count !== 8'd5) begin
            n_fail++;
            $display("FAIL pre_reset_state: trap/v/valid=%b count=%0d want 111 count=5",
                     {ovf_trap, vflag, br_valid}, ovf_count);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({zflag, vflag, nflag, br_valid, br_taken, ovf_trap} !== 6'b0
            || ovf_count !== 8'd0) begin
            n_fail++;
            $display("FAIL async_reset: outs=%b count=%0d want 000000 count=0",
                     {zflag, vflag, nflag, br_valid, br_taken, ovf_trap}, ovf_count);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_forward();
        do_reset();
        flag_we = 1; zin = 1; br_req = 1; cond = 3'b001;
        tick();
        clr_inputs();
        n_checks++;
        if ({br_valid, br_taken, zflag} !== 3'b111) begin
            n_fail++;
            $display("FAIL forward: valid/taken/z=%b want 111", {br_valid, br_taken, zflag});
        end
        // Flags hold with flag_we low even though zin changes.
        zin = 0; nin = 1;
        tick();
        n_checks++;
        if ({br_valid, br_taken, zflag, nflag} !== 4'b0010) begin
            n_fail++;
            $display("FAIL flag_hold: valid/taken/z/n=%b want 0010",
                     {br_valid, br_taken, zflag, nflag});
        end
        clr_inputs();
    endtask

    task automatic test_back_to_back();
        do_reset();
        flag_we = 1; nin = 1;
        tick();
        clr_inputs();
        br_req = 1; cond = 3'b110;
        tick();
        n_checks++;
        if ({br_valid, br_taken} !== 2'b11) begin
            n_fail++;
            $display("FAIL b2b_first: valid/taken=%b want 11", {br_valid, br_taken});
        end
        cond = 3'b100;
        tick();
        n_checks++;
        if ({br_valid, br_taken} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_second: valid/taken=%b want 10", {br_valid, br_taken});
        end
        clr_inputs();
        tick();
        n_checks++;
        if ({br_valid, br_taken} !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_end: valid/taken=%b want 00", {br_valid, br_taken});
        end
    endtask

    // Registered flags Z=1 V=1 N=0; expected taken per cond, bit i = cond i.
    task automatic test_cond_table();
        logic [7:0] exp_taken;
        exp_taken = 8'b1111_0010;
        do_reset();
        flag_we = 1; zin = 1; vin = 1; nin = 0;
        tick();
        clr_inputs();
        trap_ack = 1;
        for (int i = 0; i < 8; i++) begin
            br_req = 1; cond = 3'(i);
            tick();
            n_checks++;
            if ({br_valid, br_taken} !== {1'b1, exp_taken[i]}) begin
                n_fail++;
                $display("FAIL cond_%0d: valid/taken=%b want 1%b",
                         i, {br_valid, br_taken}, exp_taken[i]);
            end
        end
        clr_inputs();
    endtask

    task automatic test_trap();
        do_reset();
        trap_ack = 1;
        tick();
        n_checks++;
        if (ovf_trap !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_in_idle: trap=%b want 0", ovf_trap);
        end
        clr_inputs();
        flag_we = 1; vin = 1;
        tick();
        n_checks++;
        if (ovf_trap !== 1'b1 || ovf_count !== 8'd1) begin
            n_fail++;
            $display("FAIL trap_raise: trap=%b count=%0d want 1 count=1", ovf_trap, ovf_count);
        end
        trap_ack = 1;
        tick();
        n_checks++;
        if (ovf_trap !== 1'b1 || ovf_count !== 8'd2) begin
            n_fail++;
            $display("FAIL trap_rearm: trap=%b count=%0d want 1 count=2", ovf_trap, ovf_count);
        end
        clr_inputs();
        trap_ack = 1;
        tick();
        n_checks++;
        if (ovf_trap !== 1'b0 || ovf_count !== 8'd2) begin
            n_fail++;
            $display("FAIL trap_ack: trap=%b count=%0d want 0 count=2", ovf_trap, ovf_count);
        end
        clr_inputs();
    endtask

    task automatic test_saturate();
        logic [1:0] exp_cnt [4];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            flag_we = 1; vin = 1;
            tick();
            n_checks++;
            if (s_ovf_count !== exp_cnt[i]) begin
                n_fail++;
                $display("FAIL sat_count_%0d: got %0d want %0d", i, s_ovf_count, exp_cnt[i]);
            end
        end
        cnt_clr = 1;
        tick();
        n_checks++;
        if (s_ovf_count !== 2'd0 || ovf_count !== 8'd0) begin
            n_fail++;
            $display("FAIL clr_priority: got %0d/%0d want 0/0", s_ovf_count, ovf_count);
        end
        clr_inputs();
    endtask

    task automatic test_trap_disabled();
        do_reset();
        flag_we = 1; vin = 1;
        tick();
        clr_inputs();
        n_checks++;
        if (d_ovf_trap !== 1'b0 || d_ovf_count !== 8'd1) begin
            n_fail++;
            $display("FAIL trap_disabled: trap=%b count=%0d want 0 count=1",
                     d_ovf_trap, d_ovf_count);
        end
        tick();
        n_checks++;
        if (d_ovf_trap !== 1'b0 || ovf_trap !== 1'b1) begin
            n_fail++;
            $display("FAIL trap_disabled_hold: noen=%b en=%b want 0 1", d_ovf_trap, ovf_trap);
        end
    endtask

    initial begin
        clr_inputs();
        reset = 1'b1;
        test_reset();
        test_reset_mid_trap();
        test_forward();
        test_back_to_back();
        test_cond_table();
        test_trap();
        test_saturate();
        test_trap_disabled();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
